imem_loader: RTL
================

# imem_loader

Program loader that writes the instruction memory of the single-cycle MIPS core from a byte stream. It accepts bytes over a valid/ready handshake and packs them big-endian into 32-bit words. Each word is written to consecutive word-aligned instruction-memory addresses through the memory's write port. While a load is in progress it holds the core so the PC/fetch path never reads a partially written program.

## Interface
- ADDR_W, 8: instruction-memory byte-address width; matches the PC[7:0] fetch index.
- clk  input  1  rising-edge clock, shared with the core.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a load; sampled only in IDLE.
- len_words  input  ADDR_W-2  number of words to load, latched on start; 0 means 2^(ADDR_W-2) words (full memory).
- byte_in  input  8  stream data.
- byte_valid  input  1  byte_in valid.
- byte_ready  output  1  loader accepts byte_in this cycle.
- im_we  output  1  instruction-memory write enable, one cycle per word.
- im_addr  output  ADDR_W  byte address of the write; always word-aligned, so [1:0] = 0.
- im_wdata  output  32  word to write.
- cpu_hold  output  1  high while loading; the core's PC must not advance while it is high.
- busy  output  1  state is not IDLE.
- done  output  1  one-cycle pulse when the load completes.
- err  output  1  checksum mismatch flag; see Configuration.

## Operation
- States: IDLE, LOAD, WRITE, (CHECK), DONE.
- IDLE:
  - byte_ready is 0.
  - On start, latch len_words, clear the word counter, im_addr, the byte index and the checksum, clear err, then go to LOAD.
- LOAD:
  - byte_ready is 1.
  - Each handshake (byte_valid && byte_ready) shifts the byte into the word buffer. The first byte lands in [31:24] and the fourth in [7:0] (MIPS big-endian).
  - The 4th accepted byte moves the state to WRITE.
- WRITE:
  - im_we is 1 and byte_ready is 0.
  - After the write, im_addr += 4 and the word counter is incremented.
  - If the counter equals the latched length, go to CHECK (if compiled) or DONE. Otherwise return to LOAD.
- DONE: done is 1 for one cycle, then return to IDLE.
- Ignored inputs:
  - start while busy is ignored.
  - byte_valid outside LOAD/CHECK is ignored; no byte is consumed.
- Address arithmetic is modulo 2^ADDR_W. With len_words = 0 the final write lands at 2^ADDR_W − 4 and the load stops there; the address never wraps into a second pass.
- cpu_hold = busy.

## Timing
- Reset values: byte_ready=0, im_we=0, im_addr=0, im_wdata=0, cpu_hold=0, busy=0, done=0, err=0. State is IDLE.
- Reset takes effect asynchronously mid-load: im_we drops immediately and the partial word is discarded.
- start in cycle N puts the block in LOAD in cycle N+1, with byte_ready=1 in N+1.
- The 4th byte accepted in cycle N is written with im_we=1 in cycle N+1. byte_ready returns in N+2 if more words remain.
- Peak throughput is one word per 5 cycles. Source stalls (byte_valid=0) simply extend LOAD.
- done is asserted the cycle after the last WRITE, or after CHECK when compiled. busy and cpu_hold fall in the same cycle that done rises.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - After the last WRITE the block enters CHECK with byte_ready=1 and accepts exactly one checksum byte.
  - err is set in DONE if (sum of all data bytes + checksum byte) mod 256 ≠ 0.
  - err stays set until the next start.
- Not defined: the CHECK state is absent and err is tied to 0.

## Structure
- Package imem_loader_pkg holds:
  - the state enum (IDLE, LOAD, WRITE, CHECK, DONE);
  - BYTES_PER_WORD = 4;
  - WORD_W = 32.
- Sub-module word_packer: a byte-index counter plus a shift register. Its outputs are the word and a word_full signal. The FSM and address/word counters stay in imem_loader.

## Test plan
- Reset mid-load: assert rst_n=0 after 2 bytes of word 1 → im_we=0 immediately. After release, busy=0, im_addr=0, and the next load starts at address 0.
- Basic load:
  - Stimulus: len_words=2, bytes 20 08 00 05 8C 09 00 04 streamed back-to-back.
  - Response: im_we pulses write 0x20080005 @0x00 and 0x8C090004 @0x04.
  - done pulses one cycle after the second write; cpu_hold is high from start+1 until done.
- Stalled source: byte_valid low for 3 cycles between bytes 2 and 3 → same word written, one im_we pulse, and no byte is duplicated or dropped.
- Full memory: len_words=0, 256 bytes → 64 writes with addresses 0x00…0xFC, then done. The address never returns to 0 within the load.
- Ignored inputs:
  - start asserted during LOAD → no effect on len or address.
  - byte_valid=1 in IDLE → byte_ready=0 and no write.
- Checksum (with IMEM_LOADER_CHECKSUM_EN): len_words=1, bytes 01 02 03 04 then checksum F6 → err=0. Checksum F7 → err=1 at done.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
    CHECK,
    DONE
  } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Loader control, byte-stream and instruction-memory write-port signals.
interface imem_loader_if
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 8
);

  logic              start;
  logic [ADDR_W-3:0] len_words;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [WORD_W-1:0] im_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, len_words, byte_in, byte_valid,
    input  byte_ready, im_we, im_addr, im_wdata, cpu_hold, busy, done, err
  );

  modport slave (
    input  start, len_words, byte_in, byte_valid,
    output byte_ready, im_we, im_addr, im_wdata, cpu_hold, busy, done, err
  );

endinterface

// File: rtl/word_packer.sv
// Packs accepted bytes big-endian into a word: first byte ends up in [31:24].
module word_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              shift_en,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word,
  output logic              word_full
);

  localparam int IDX_W = $clog2(BYTES_PER_WORD);

  logic [IDX_W-1:0]  idx;
  logic [WORD_W-9:0] shreg;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx   <= '0;
      shreg <= '0;
    end else if (clear) begin
      idx   <= '0;
      shreg <= '0;
    end else if (shift_en) begin
      idx   <= idx + IDX_W'(1);
      shreg <= {shreg[WORD_W-17:0], byte_in};
    end
  end

  // The word is complete in the same cycle its last byte is handed over.
  assign word      = {shreg, byte_in};
  assign word_full = shift_en && (idx == IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Streams bytes into instruction memory one word at a time while holding the core.
// Optional trailing checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 8
)(
  input  logic         clk,
  input  logic         rst_n,
  imem_loader_if.slave bus
);

  state_t            state;
  logic [ADDR_W-3:0] len_q;
  logic [ADDR_W-3:0] word_cnt;
  logic [ADDR_W-3:0] cnt_inc;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic              ready_q;
  logic              we_q;
  logic              busy_q;
  logic              done_q;

  logic              start_fire;
  logic              hs;
  logic              shift_en;
  logic [WORD_W-1:0] pk_word;
  logic              pk_full;

  assign start_fire = (state == IDLE) && bus.start;
  assign hs         = bus.byte_valid && ready_q;
  assign shift_en   = hs && (state == LOAD);
  assign cnt_inc    = word_cnt + 1'b1;

  word_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (start_fire),
    .shift_en  (shift_en),
    .byte_in   (bus.byte_in),
    .word      (pk_word),
    .word_full (pk_full)
  );

  // NOTE: asynchronous reset clears every control flop, so a load cut short
  // drops im_we at once and no partial word survives into the next load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      len_q    <= '0;
      word_cnt <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ready_q  <= 1'b0;
      we_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            len_q    <= bus.len_words;
            word_cnt <= '0;
            addr_q   <= '0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (pk_full) begin
            wdata_q <= pk_word;
            we_q    <= 1'b1;
            ready_q <= 1'b0;
            state   <= WRITE;
          end
        end
        WRITE: begin
          addr_q   <= addr_q + ADDR_W'(BYTES_PER_WORD);
          word_cnt <= cnt_inc;
          // len_words == 0 wraps cnt_inc back to 0 after a full memory.
          if (cnt_inc == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            ready_q <= 1'b1;
            state   <= CHECK;
`else
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state   <= DONE;
`endif
          end else begin
            ready_q <= 1'b1;
            state   <= LOAD;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHECK: begin
          if (hs) begin
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state   <= DONE;
          end
        end
`endif
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] sum_q;
  logic       err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      err_q <= 1'b0;
    end else if (start_fire) begin
      sum_q <= '0;
      err_q <= 1'b0;
    end else if (shift_en) begin
      sum_q <= sum_q + bus.byte_in;
    end else if (hs && (state == CHECK)) begin
      err_q <= (sum_q + bus.byte_in) != 8'd0;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.byte_ready = ready_q;
  assign bus.im_we      = we_q;
  assign bus.im_addr    = addr_q;
  assign bus.im_wdata   = wdata_q;
  assign bus.busy       = busy_q;
  assign bus.cpu_hold   = busy_q;
  assign bus.done       = done_q;

endmodule
